// File: rtl/lock_pkg.sv
// Shared state encoding, default sizes and code-digit helper for the keypad lock sequencer.
package lock_pkg;

  localparam int LOCK_DIGIT_W  = 4;
  localparam int LOCK_CODE_LEN = 4;

  typedef enum logic [2:0] {
    ST_LOCKED   = 3'd0,
    ST_ENTRY    = 3'd1,
    ST_UNLOCKED = 3'd2,
    ST_ERROR    = 3'd3,
    ST_LOCKOUT  = 3'd4,
    ST_PROGRAM  = 3'd5
  } lock_state_t;

  // Digit idx of a packed code; digit k lives at bits [k*digit_w +: digit_w].
  function automatic logic [15:0] code_digit(input logic [63:0] code, input int idx,
                                             input int digit_w);
    logic [63:0] mask;
    mask = (64'd1 << digit_w) - 64'd1;
    return 16'((code >> (idx * digit_w)) & mask);
  endfunction

endpackage

// File: rtl/lock_timer.sv
// Shared up-counter for entry timeout, error hold and lockout; tc flags the terminal count.
module lock_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] tc_val,
  output logic             tc
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign tc = en & (count == tc_val);

endmodule

// File: rtl/lock_entry_sequencer.sv
// Multi-digit keypad lock: code entry with timeout, failure lockout and reprogramming.
//
//   state    | meaning
//   LOCKED   | idle, waiting for the first digit
//   ENTRY    | collecting digits, idle timeout armed
//   UNLOCKED | code accepted; press relocks, press with prog_en reprograms
//   ERROR    | wrong code or timeout, error_led held
//   LOCKOUT  | too many failures, presses ignored
//   PROGRAM  | writing a new code one digit per press
module lock_entry_sequencer
  import lock_pkg::*;
#(
  parameter int                          CODE_LEN       = LOCK_CODE_LEN,
  parameter int                          DIGIT_W        = LOCK_DIGIT_W,
  parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE   = 16'h4321,
  parameter int                          MAX_TRIES      = 3,
  parameter int                          ERR_CYCLES     = 8,
  parameter int                          TIMEOUT_CYCLES = 4096,
  parameter int                          LOCKOUT_CYCLES = 1024,
  parameter int                          CNT_W          = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DIGIT_W-1:0] digit,
  input  logic               enter,
  input  logic               prog_en,
  output logic               locked_led,
  output logic               unlocked_led,
  output logic               error_led,
  output logic               lockout_led,
  output logic [2:0]         state_leds,
  output logic [2:0]         digit_idx
);

  localparam int CODE_W = CODE_LEN * DIGIT_W;
  localparam int FAIL_W = $clog2(MAX_TRIES + 1);

  lock_state_t        state;
  logic               enter_q;
  logic [CODE_W-1:0]  code_r;
  logic [FAIL_W-1:0]  fail_cnt;
  logic [FAIL_W-1:0]  fail_sat_inc;
  logic               mismatch;
  logic [DIGIT_W-1:0] cur_digit;
  logic               digit_ne;
  logic               last_digit;
  logic               accept;
  logic               timer_clr;
  logic               timer_en;
  logic               timer_tc;
  logic [CNT_W-1:0]   tc_val;

  always_comb begin
    accept       = enter & ~enter_q &
                   (state inside {ST_LOCKED, ST_ENTRY, ST_UNLOCKED, ST_PROGRAM});
    cur_digit    = DIGIT_W'(code_digit(64'(code_r), int'(digit_idx), DIGIT_W));
    digit_ne     = (digit != cur_digit);
    last_digit   = (digit_idx == 3'(CODE_LEN - 1));
    fail_sat_inc = (fail_cnt >= FAIL_W'(MAX_TRIES)) ? fail_cnt : fail_cnt + 1'b1;
  end

  // Only one timed interval is live per state, so a single counter is shared.
  always_comb begin
    timer_en = 1'b0;
    tc_val   = '0;
    case (state)
      ST_ENTRY, ST_PROGRAM: begin
        timer_en = 1'b1;
        tc_val   = CNT_W'(TIMEOUT_CYCLES - 1);
      end
      ST_ERROR: begin
        timer_en = 1'b1;
        tc_val   = CNT_W'(ERR_CYCLES - 1);
      end
      ST_LOCKOUT: begin
        timer_en = 1'b1;
        tc_val   = CNT_W'(LOCKOUT_CYCLES - 1);
      end
      default: ;
    endcase
  end

  // Every accepted press and every expiry leaves the timer at zero for the next interval.
  assign timer_clr = accept | timer_tc;

  lock_timer #(.CNT_W(CNT_W)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clr    (timer_clr),
    .en     (timer_en),
    .tc_val (tc_val),
    .tc     (timer_tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_LOCKED;
      enter_q   <= 1'b0;
      digit_idx <= '0;
      fail_cnt  <= '0;
      mismatch  <= 1'b0;
      code_r    <= DEFAULT_CODE;
    end else begin
      enter_q <= enter;
      case (state)
        ST_LOCKED: begin
          if (accept) begin
            mismatch  <= digit_ne;
            digit_idx <= 3'd1;
            state     <= ST_ENTRY;
          end
        end
        ST_ENTRY: begin
          if (accept) begin
            if (last_digit) begin
              digit_idx <= '0;
              if (mismatch | digit_ne) begin
                fail_cnt <= fail_sat_inc;
                state    <= ST_ERROR;
              end else begin
                fail_cnt <= '0;
                state    <= ST_UNLOCKED;
              end
            end else begin
              mismatch  <= mismatch | digit_ne;
              digit_idx <= digit_idx + 3'd1;
            end
          end else if (timer_tc) begin
            digit_idx <= '0;
            fail_cnt  <= fail_sat_inc;
            state     <= ST_ERROR;
          end
        end
        ST_ERROR: begin
          if (timer_tc) begin
            state <= (fail_cnt >= FAIL_W'(MAX_TRIES)) ? ST_LOCKOUT : ST_LOCKED;
          end
        end
        ST_LOCKOUT: begin
          if (timer_tc) begin
            fail_cnt <= '0;
            state    <= ST_LOCKED;
          end
        end
        ST_UNLOCKED: begin
          if (accept) begin
            digit_idx <= '0;
            state     <= prog_en ? ST_PROGRAM : ST_LOCKED;
          end
        end
        ST_PROGRAM: begin
          if (accept) begin
            for (int k = 0; k < CODE_LEN; k++) begin
              if (digit_idx == 3'(k)) code_r[k*DIGIT_W +: DIGIT_W] <= digit;
            end
            if (last_digit) begin
              digit_idx <= '0;
              state     <= ST_UNLOCKED;
            end else begin
              digit_idx <= digit_idx + 3'd1;
            end
          end else if (timer_tc) begin
            // Digits already written are kept; a partial new code is possible.
            digit_idx <= '0;
            state     <= ST_UNLOCKED;
          end
        end
        default: state <= ST_LOCKED;
      endcase
    end
  end

  assign state_leds   = state;
  assign locked_led   = (state == ST_LOCKED) || (state == ST_ENTRY);
  assign unlocked_led = (state == ST_UNLOCKED) || (state == ST_PROGRAM);
  assign error_led    = (state == ST_ERROR);
  assign lockout_led  = (state == ST_LOCKOUT);

endmodule

// File: tb/tb_lock_entry_sequencer.sv
// Directed bench for lock_entry_sequencer: per-cycle vector table plus multi-cycle sequences.
module tb_lock_entry_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] digit;
  logic       enter;
  logic       prog_en;
  logic       locked_led, unlocked_led, error_led, lockout_led;
  logic [2:0] state_leds, digit_idx;
  logic [9:0] obs;

  int errors = 0;
  int checks = 0;

  lock_entry_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .digit        (digit),
    .enter        (enter),
    .prog_en      (prog_en),
    .locked_led   (locked_led),
    .unlocked_led (unlocked_led),
    .error_led    (error_led),
    .lockout_led  (lockout_led),
    .state_leds   (state_leds),
    .digit_idx    (digit_idx)
  );

  always #5 clk = ~clk;

  assign obs = {state_leds, digit_idx, locked_led, unlocked_led, error_led, lockout_led};

  typedef struct {
    logic [3:0] digit;
    logic       enter;
    logic       prog;
    int         st;
    int         idx;
  } vec_t;

  vec_t tv[26];

  function automatic vec_t mk(input int d, input int e, input int p, input int st, input int idx);
    vec_t v;
    v.digit = 4'(d);
    v.enter = 1'(e);
    v.prog  = 1'(p);
    v.st    = st;
    v.idx   = idx;
    return v;
  endfunction

  // Expected output bundle from state and index, using the LED decode of each state.
  function automatic logic [9:0] model_out(input int st, input int idx);
    logic l, u, e, o;
    l = (st == 0) || (st == 1);
    u = (st == 2) || (st == 5);
    e = (st == 3);
    o = (st == 4);
    return {3'(st), 3'(idx), l, u, e, o};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string name, input int st, input int idx);
    chk(name, 32'(obs), 32'(model_out(st, idx)));
  endtask

  task automatic press(input int d, input logic p);
    @(negedge clk);
    digit   = 4'(d);
    prog_en = p;
    enter   = 1'b1;
    @(negedge clk);
    enter   = 1'b0;
  endtask

  task automatic code4(input int a, input int b, input int c, input int d);
    press(a, 1'b0);
    press(b, 1'b0);
    press(c, 1'b0);
    press(d, 1'b0);
  endtask

  // Counts falling edges until state_leds leaves its current value.
  task automatic wait_change(input int budget, output int n);
    logic [2:0] s0;
    s0 = state_leds;
    n  = 0;
    while (state_leds == s0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (state_leds == s0) begin
      checks++;
      errors++;
      $display("FAIL wait_change: state %0d unchanged after %0d cycles", s0, budget);
    end
  endtask

  initial begin
    int n;

    tv[0]  = mk(1, 1, 0, 1, 1);
    tv[1]  = mk(1, 1, 0, 1, 1);
    tv[2]  = mk(0, 0, 0, 1, 1);
    tv[3]  = mk(2, 1, 0, 1, 2);
    tv[4]  = mk(2, 0, 0, 1, 2);
    tv[5]  = mk(3, 1, 0, 1, 3);
    tv[6]  = mk(3, 0, 0, 1, 3);
    tv[7]  = mk(4, 1, 0, 2, 0);
    tv[8]  = mk(4, 0, 0, 2, 0);
    tv[9]  = mk(0, 1, 0, 0, 0);
    tv[10] = mk(0, 0, 0, 0, 0);
    tv[11] = mk(1, 1, 0, 1, 1);
    tv[12] = mk(1, 0, 0, 1, 1);
    tv[13] = mk(2, 1, 0, 1, 2);
    tv[14] = mk(2, 0, 0, 1, 2);
    tv[15] = mk(3, 1, 0, 1, 3);
    tv[16] = mk(3, 0, 0, 1, 3);
    tv[17] = mk(5, 1, 0, 3, 0);
    tv[18] = mk(5, 0, 0, 3, 0);
    tv[19] = mk(0, 0, 0, 3, 0);
    tv[20] = mk(1, 1, 0, 3, 0);
    tv[21] = mk(1, 0, 0, 3, 0);
    tv[22] = mk(0, 0, 0, 3, 0);
    tv[23] = mk(0, 0, 0, 3, 0);
    tv[24] = mk(0, 0, 0, 3, 0);
    tv[25] = mk(0, 0, 0, 0, 0);

    reset   = 1'b1;
    enter   = 1'b0;
    prog_en = 1'b0;
    digit   = 4'd0;
    repeat (3) @(negedge clk);
    chk_state("reset_held", 0, 0);
    reset = 1'b0;
    @(negedge clk);
    chk_state("reset_release", 0, 0);

    // Per-cycle vectors: correct code, relock, wrong last digit, ignored press in ERROR.
    for (int i = 0; i < 26; i++) begin
      digit   = tv[i].digit;
      enter   = tv[i].enter;
      prog_en = tv[i].prog;
      @(negedge clk);
      chk($sformatf("vec%0d", i), 32'(obs), 32'(model_out(tv[i].st, tv[i].idx)));
    end

    // Success clears the failure count left by the table.
    code4(1, 2, 3, 4);
    chk_state("unlock_1234", 2, 0);
    press(0, 1'b0);
    chk_state("relock", 0, 0);

    code4(9, 2, 3, 4);
    chk_state("wrong_first_digit", 3, 0);
    wait_change(20, n);
    chk("error_len_1", 32'(n), 32'd8);
    chk_state("after_fail1", 0, 0);
    code4(1, 2, 3, 5);
    chk_state("wrong_last_digit", 3, 0);
    wait_change(20, n);
    chk_state("after_fail2_not_lockout", 0, 0);
    code4(1, 2, 4, 3);
    chk_state("third_fail", 3, 0);
    wait_change(20, n);
    chk("error_len_3", 32'(n), 32'd8);
    chk_state("lockout_entry", 4, 0);
    press(1, 1'b0);
    chk_state("press_in_lockout", 4, 0);
    wait_change(2000, n);
    chk("lockout_len", 32'(n + 2), 32'd1024);
    chk_state("lockout_exit", 0, 0);
    code4(1, 2, 3, 4);
    chk_state("unlock_after_lockout", 2, 0);
    press(0, 1'b0);

    // Entry timeout after one digit.
    press(1, 1'b0);
    chk_state("timeout_first_digit", 1, 1);
    wait_change(5000, n);
    chk("timeout_len", 32'(n), 32'd4096);
    chk_state("timeout_error", 3, 0);
    wait_change(20, n);
    chk_state("timeout_recover", 0, 0);

    // Press on the same edge as the timeout expiry.
    press(1, 1'b0);
    repeat (4094) @(negedge clk);
    press(2, 1'b0);
    chk_state("press_beats_timeout", 1, 2);
    press(3, 1'b0);
    press(4, 1'b0);
    chk_state("unlock_late_digit", 2, 0);
    press(0, 1'b0);

    // Held enter gives one press.
    @(negedge clk);
    digit = 4'd1;
    enter = 1'b1;
    repeat (50) @(negedge clk);
    enter = 1'b0;
    chk_state("held_enter", 1, 1);
    press(2, 1'b0);
    press(3, 1'b0);
    press(4, 1'b0);
    chk_state("unlock_after_hold", 2, 0);

    // Reprogram to 9876.
    press(0, 1'b1);
    chk_state("enter_program", 5, 0);
    press(9, 1'b0);
    chk_state("prog_d0", 5, 1);
    press(8, 1'b0);
    chk_state("prog_d1", 5, 2);
    press(7, 1'b0);
    chk_state("prog_d2", 5, 3);
    press(6, 1'b0);
    chk_state("prog_done", 2, 0);
    press(0, 1'b0);
    chk_state("relock_new", 0, 0);
    code4(1, 2, 3, 4);
    chk_state("old_code_rejected", 3, 0);
    wait_change(20, n);
    code4(9, 8, 7, 6);
    chk_state("new_code_accepted", 2, 0);

    // Program timeout keeps the partially written code.
    press(0, 1'b1);
    press(5, 1'b0);
    chk_state("partial_prog", 5, 1);
    wait_change(5000, n);
    chk("prog_timeout_len", 32'(n), 32'd4096);
    chk_state("prog_timeout_exit", 2, 0);
    press(0, 1'b0);
    code4(5, 8, 7, 6);
    chk_state("partial_code_live", 2, 0);

    // Asynchronous reset mid-entry restores the default code.
    press(0, 1'b0);
    press(5, 1'b0);
    press(8, 1'b0);
    chk_state("two_digits", 1, 2);
    #2 reset = 1'b1;
    #1 chk_state("async_reset", 0, 0);
    @(negedge clk);
    reset = 1'b0;
    code4(1, 2, 3, 4);
    chk_state("default_code_restored", 2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
